// File: rtl/logic_op_responder.sv
// Two-stage handshaked responder for the 4-operand logical-operator interface.
// Stage 1 registers operands/opcode, stage 2 registers the scalar (x) and bitwise (y) results.
module logic_op_responder #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             x,
    output logic [W-1:0]     y,
    output logic [CNT_W-1:0] op_count,
    output logic             err
);

    localparam logic [2:0] OpAndOr = 3'd0;
    localparam logic [2:0] OpOrAnd = 3'd1;
    localparam logic [2:0] OpNand4 = 3'd2;
    localparam logic [2:0] OpXor4  = 3'd3;
    localparam logic [2:0] OpEqNe  = 3'd4;

    logic             s1_valid_q;
    logic [W-1:0]     s1_a_q, s1_b_q, s1_c_q, s1_d_q;
    logic [2:0]       s1_op_q;
    logic             s2_valid_q;
    logic             x_q;
    logic [W-1:0]     y_q;
    logic [CNT_W-1:0] op_count_q;
    logic             err_q;

    logic             s1_load, s2_load;
    logic             x_d;
    logic [W-1:0]     y_d;
    logic             rsv_d;

    // Ready ripples back combinationally from out_ready; there is no skid buffer.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = rst_n && s1_load;

    always_comb begin
        x_d   = 1'b0;
        y_d   = '0;
        rsv_d = 1'b0;
        case (s1_op_q)
            OpAndOr: begin
                x_d = ((|s1_a_q) && (|s1_b_q)) || ((|s1_c_q) && (|s1_d_q));
                y_d = (s1_a_q & s1_b_q) | (s1_c_q & s1_d_q);
            end
            OpOrAnd: begin
                x_d = ((|s1_a_q) || (|s1_b_q)) && ((|s1_c_q) || (|s1_d_q));
                y_d = (s1_a_q | s1_b_q) & (s1_c_q | s1_d_q);
            end
            OpNand4: begin
                x_d = !((|s1_a_q) && (|s1_b_q) && (|s1_c_q) && (|s1_d_q));
                y_d = ~(s1_a_q & s1_b_q & s1_c_q & s1_d_q);
            end
            OpXor4: begin
                y_d = s1_a_q ^ s1_b_q ^ s1_c_q ^ s1_d_q;
                x_d = ^y_d;
            end
            OpEqNe: begin
                x_d = (s1_a_q == s1_b_q) && (s1_c_q != s1_d_q);
                y_d = ~(s1_a_q ^ s1_b_q);
            end
            default: rsv_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            s1_d_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            x_q        <= 1'b0;
            y_q        <= '0;
            op_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_a_q  <= a;
                    s1_b_q  <= b;
                    s1_c_q  <= c;
                    s1_d_q  <= d;
                    s1_op_q <= op;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    x_q <= x_d;
                    y_q <= y_d;
                    if (rsv_d) begin
                        err_q <= 1'b1;
                    end
                end
            end
            if (s2_valid_q && out_ready) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign op_count  = op_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_logic_op_responder.sv
// Randomised and directed bench for logic_op_responder against a behavioural result model.
module tb_logic_op_responder;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = '0, b = '0, c = '0, d = '0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             x;
    logic [W-1:0]     y;
    logic [CNT_W-1:0] op_count;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic         x;
        logic [W-1:0] y;
        logic         rsv;
    } res_t;

    logic [W-1:0] va = 4'b0001, vb = 4'b0010, vc = 4'b1100, vd = 4'b1010;

    logic_op_responder #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .op_count(op_count), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-bit truth evaluation and bit counting.
    function automatic res_t model(input logic [2:0] f, input logic [W-1:0] ia, ib, ic, id);
        res_t r;
        bit na, nb, nc, nd;
        na = (ia != 0); nb = (ib != 0); nc = (ic != 0); nd = (id != 0);
        r = '0;
        case (f)
            3'd0: begin
                r.x = (na && nb) || (nc && nd);
                for (int i = 0; i < W; i++) r.y[i] = (ia[i] && ib[i]) || (ic[i] && id[i]);
            end
            3'd1: begin
                r.x = (na || nb) && (nc || nd);
                for (int i = 0; i < W; i++) r.y[i] = (ia[i] || ib[i]) && (ic[i] || id[i]);
            end
            3'd2: begin
                r.x = !(na && nb && nc && nd);
                for (int i = 0; i < W; i++) r.y[i] = !(ia[i] && ib[i] && ic[i] && id[i]);
            end
            3'd3: begin
                for (int i = 0; i < W; i++)
                    r.y[i] = ((int'(ia[i]) + int'(ib[i]) + int'(ic[i]) + int'(id[i])) % 2) == 1;
                r.x = ($countones(r.y) % 2) == 1;
            end
            3'd4: begin
                r.x = (ia == ib) && (ic != id);
                for (int i = 0; i < W; i++) r.y[i] = (ia[i] == ib[i]);
            end
            default: r.rsv = 1'b1;
        endcase
        return r;
    endfunction

    task automatic rand_set(input int max_op);
        a  = W'($urandom);
        b  = W'($urandom);
        c  = W'($urandom);
        d  = W'($urandom);
        op = 3'($urandom_range(0, max_op));
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, x, y, op_count, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b x=%b y=%b cnt=%0d err=%b, expected all 0",
                     out_valid, x, y, op_count, err);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b, expected 0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_release: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        a = va; b = vb; c = vc; d = vd; op = 3'd0;
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_early: out_valid=%b after 1 cycle, expected 0", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || x !== 1'b1 || y !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_result: ov=%b x=%b y=%b, expected ov=1 x=1 y=1000",
                     out_valid, x, y);
        end
        @(negedge clk);
        n_tests++;
        if (op_count !== 8'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_count: cnt=%0d ov=%b, expected cnt=1 ov=0", op_count, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        res_t exp_r[4];
        int sent, got, first, last;
        exp_r[0] = {1'b1, 4'b0010, 1'b0};
        exp_r[1] = {1'b0, 4'b1111, 1'b0};
        exp_r[2] = {1'b0, 4'b0101, 1'b0};
        exp_r[3] = {1'b0, 4'b1100, 1'b0};
        apply_reset();
        out_ready = 1'b1;
        a = va; b = vb; c = vc; d = vd;
        sent = 0; got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (sent < 4) begin
                in_valid = 1'b1;
                op = 3'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                n_tests++;
                if (got > 3 || {x, y} !== {exp_r[got].x, exp_r[got].y}) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: x=%b y=%b, expected x=%b y=%b", got, x, y,
                             exp_r[got & 3].x, exp_r[got & 3].y);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 4 || last - first != 3) begin
            n_fail++;
            $display("FAIL b2b_stream: got %0d results over %0d cycles, expected 4 over 4",
                     got, last - first + 1);
        end
        n_tests++;
        if (op_count !== 8'd4) begin
            n_fail++;
            $display("FAIL b2b_count: cnt=%0d, expected 4", op_count);
        end
    endtask

    task automatic test_backpressure();
        res_t exp_r[3];
        logic [W-1:0] sa[3], sb[3], sc[3], sd[3];
        logic [2:0] so[3];
        int got;
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_set(4);
            sa[k] = a; sb[k] = b; sc[k] = c; sd[k] = d; so[k] = op;
            exp_r[k] = model(op, a, b, c, d);
        end
        for (int k = 0; k < 2; k++) begin
            a = sa[k]; b = sb[k]; c = sc[k]; d = sd[k]; op = so[k];
            in_valid = 1'b1;
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_accept[%0d]: in_ready=%b, expected 1", k, in_ready);
            end
            @(posedge clk);
            #1;
        end
        a = sa[2]; b = sb[2]; c = sc[2]; d = sd[2]; op = so[2];
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {x, y} !== {exp_r[0].x, exp_r[0].y}) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: in_ready=%b ov=%b x=%b y=%b, expected 0 1 %b %b",
                         s, in_ready, out_valid, x, y, exp_r[0].x, exp_r[0].y);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                n_tests++;
                if ({x, y} !== {exp_r[got].x, exp_r[got].y}) begin
                    n_fail++;
                    $display("FAIL bp_drain[%0d]: x=%b y=%b, expected x=%b y=%b", got, x, y,
                             exp_r[got].x, exp_r[got].y);
                end
                got++;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (got != 3 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, ov=%b after drain, expected 3 and 0",
                     got, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reserved();
        logic [2:0] ops[4];
        res_t exp_r[4];
        int sent, got;
        bit seen;
        ops[0] = 3'd6; ops[1] = 3'd0; ops[2] = 3'd3; ops[3] = 3'd1;
        apply_reset();
        out_ready = 1'b1;
        rand_set(4);
        a = a | 4'b0001; // force nonzero operands so a stray result would be visible
        for (int k = 0; k < 4; k++) exp_r[k] = model(ops[k], a, b, c, d);
        sent = 0; got = 0; seen = 0;
        for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
            if (sent < 4) begin
                in_valid = 1'b1;
                op = ops[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                n_tests++;
                if ({x, y} !== {exp_r[got].x, exp_r[got].y}) begin
                    n_fail++;
                    $display("FAIL rsv_result[%0d]: x=%b y=%b, expected x=%b y=%b", got, x, y,
                             exp_r[got].x, exp_r[got].y);
                end
                seen = 1;
                got++;
            end
            if (seen) begin
                n_tests++;
                if (err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rsv_err_sticky: err=%b, expected 1", err);
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL rsv_count: got %0d results, expected 4", got);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        apply_reset();
        out_ready = 1'b1;
        rand_set(4);
        a = 4'b1111; b = 4'b1111;
        op = 3'd0;
        in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rand_set(4);
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mf_inflight: out_valid=%b, expected 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, x, y, op_count, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL mf_async_clear: ov=%b x=%b y=%b cnt=%0d rdy=%b, expected all 0",
                     out_valid, x, y, op_count, in_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0 || op_count !== '0) begin
            n_fail++;
            $display("FAIL mf_no_stale: %0d stale results, cnt=%0d, expected 0 and 0",
                     seen, op_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        res_t q[$];
        res_t r;
        int sent, got;
        bit acc;
        apply_reset();
        out_ready = 1'b1;
        sent = 0; got = 0; acc = 0;
        for (int cyc = 0; cyc < 300 && got < 256; cyc++) begin
            if (sent < 256) begin
                if (!in_valid || acc) rand_set(4);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = 0;
            @(negedge clk);
            n_tests++;
            if (op_count !== CNT_W'(got)) begin
                n_fail++;
                $display("FAIL wrap_count: cnt=%0d, expected %0d", op_count, got % 256);
            end
            if (out_valid) begin
                r = (q.size() > 0) ? q.pop_front() : '0;
                n_tests++;
                if ({x, y} !== {r.x, r.y}) begin
                    n_fail++;
                    $display("FAIL wrap_result[%0d]: x=%b y=%b, expected x=%b y=%b",
                             got, x, y, r.x, r.y);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(op, a, b, c, d));
                sent++;
                acc = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 256 || op_count !== '0) begin
            n_fail++;
            $display("FAIL wrap_final: got %0d results, cnt=%0d, expected 256 and 0",
                     got, op_count);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t r;
        int got, issued;
        bit acc, err_exp;
        apply_reset();
        got = 0; issued = 0; acc = 0; err_exp = 0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            if (!in_valid || acc) begin
                in_valid = (cyc < 400) && ($urandom % 4 != 0);
                if (in_valid) rand_set(7);
            end
            out_ready = (cyc >= 400) || ($urandom % 3 != 0);
            acc = 0;
            @(negedge clk);
            if (out_valid && q.size() > 0 && q[0].rsv) err_exp = 1;
            n_tests++;
            if (err !== err_exp) begin
                n_fail++;
                $display("FAIL rand_err: err=%b, expected %b", err, err_exp);
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: unexpected result x=%b y=%b, expected none", x, y);
                end else begin
                    r = q.pop_front();
                    if ({x, y} !== {r.x, r.y}) begin
                        n_fail++;
                        $display("FAIL rand_result[%0d]: x=%b y=%b, expected x=%b y=%b",
                                 got, x, y, r.x, r.y);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(op, a, b, c, d));
                issued++;
                acc = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (q.size() != 0 || got != issued || op_count !== CNT_W'(got)) begin
            n_fail++;
            $display("FAIL rand_drain: %0d left, got %0d of %0d, cnt=%0d, expected 0 left, cnt=%0d",
                     q.size(), got, issued, op_count, got % 256);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reserved();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_op_responder.md
Name: logic_op_responder

Overview:
Pipelined, handshaked responder for the 4-operand logical-operator interface (operands a, b, c, d; result x). An initiator presents an operand set plus opcode with valid/ready. The block evaluates the selected logical function over two registered stages and returns a scalar logical result x and a bitwise companion result y, with output backpressure. It sits between an operand source (sequencer or bench) and a result consumer.

Parameters:
W, 4, operand and y width (W >= 2)
CNT_W, 8, width of completed-result counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block accepts operand set this cycle
a  input  W  operand a
b  input  W  operand b
c  input  W  operand c
d  input  W  operand d
op  input  3  function select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
x  output  1  logical (scalar) result
y  output  W  bitwise result
op_count  output  CNT_W  completed output handshakes, wrapping
err  output  1  sticky: a reserved opcode was accepted

Behaviour:
- Reset (rst_n=0, async): s1_valid=0, s2_valid=0, out_valid=0, x=0, y=0, op_count=0, err=0. in_ready is 0 while rst_n=0 and 1 on the first cycle after release. Asserting reset mid-operation discards all in-flight data; no result is emitted for it.
- Handshakes: input transfer when in_valid&&in_ready at a clk edge; output transfer when out_valid&&out_ready.
- Stage 1 captures a, b, c, d and op on input transfer (s1_valid=1).
- Stage 2 computes from stage-1 registers and registers x and y (s2_valid drives out_valid).
- Stall logic: s2_load = !s2_valid || out_ready. s1_load = !s1_valid || s2_load. in_ready = s1_load (combinational from out_ready; no skid buffer).
- Stage 1 to stage 2 moves when s1_valid && s2_load. s1_valid clears if no new input arrives in the same cycle. s2_valid clears on output transfer with nothing advancing.
- Latency: 2 cycles from input transfer edge to out_valid=1 with out_ready held high. Throughput is 1 result per cycle.
- While out_valid=1 and out_ready=0, x and y hold stable. Order is strictly preserved.
- Opcodes ("nonzero" means any bit set):
  - op=0: x=(a&&b)||(c&&d); y=(a&b)|(c&d)
  - op=1: x=(a||b)&&(c||d); y=(a|b)&(c|d)
  - op=2: x=!(a&&b&&c&&d); y=~(a&b&c&d)
  - op=3: y=a^b^c^d; x=^y (reduction XOR)
  - op=4: x=(a==b)&&(c!=d); y=~(a^b)
  - op=5..7: reserved; result x=0, y=0 is still emitted. err is set when the reserved op enters stage 2. err clears only on reset.
- op_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Simultaneous input transfer and output transfer in a full pipe is legal: both stages advance and no data is lost or duplicated.
- x and y are registered outputs with no combinational path from inputs.

Test Plan:
- Reset then op=0, a=0001, b=0010, c=1100, d=1010, out_ready=1 -> out_valid=1 exactly 2 cycles after accept, x=1, y=1000, op_count=1.
- Same operands, op=1,2,3,4 back-to-back, one per cycle -> in order: (x=1, y=0010), (x=0, y=1111), (x=0, y=0101), (x=0, y=1100). Four consecutive out_valid cycles; op_count=4.
- Backpressure: out_ready=0 while feeding 3 sets -> 2 accepted, then in_ready=0. x and y stay stable. Release out_ready -> all 3 results emerge in order with no loss or duplicate.
- op=6 with any operands -> x=0, y=0000, err=1 and err stays 1 through subsequent valid ops until reset.
- Reset pulse (rst_n=0 for 1 cycle, asynchronous, mid-clock) with 2 sets in flight -> outputs clear immediately, no stale result emitted, op_count=0.
- 256 output transfers with CNT_W=8 -> op_count wraps to 0.
